// File: rtl/led_pattern_bank_if.sv
// Configuration write port for led_pattern_bank.
//   cfg_valid   : write request (master -> slave)
//   cfg_ready   : slave can accept a write (slave -> master)
//   cfg_channel : target channel index
//   cfg_mode    : 0=OFF 1=ON 2=BLINK 3=BREATHE
//   cfg_period  : ticks per blink half-period / per breathe duty step
interface led_pattern_bank_if #(
    parameter int unsigned CH_W         = 3,
    parameter int unsigned PERIOD_WIDTH = 16
) ();
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [CH_W-1:0]         cfg_channel;
    logic [1:0]              cfg_mode;
    logic [PERIOD_WIDTH-1:0] cfg_period;

    modport master (
        output cfg_valid, cfg_channel, cfg_mode, cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_channel, cfg_mode, cfg_period,
        output cfg_ready
    );
endinterface

// File: rtl/led_pattern_bank.sv
// Multi-channel LED pattern generator: each channel runs OFF, ON, BLINK
// (square wave) or BREATHE (triangle-ramped PWM), configured through a
// single-cycle valid/ready write port.
//   i_clock : system clock, rising edge
//   i_reset : synchronous, active-high reset
//   cfg     : configuration write port (slave side)
//   o_leds  : registered LED drive, bit n = channel n
//   o_tick  : one-cycle pulse every TICK_DIV clocks
module led_pattern_bank #(
    parameter int unsigned CHANNELS     = 8,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned PWM_BITS     = 8
) (
    input  logic                i_clock,
    input  logic                i_reset,
    led_pattern_bank_if.slave   cfg,
    output logic [CHANNELS-1:0] o_leds,
    output logic                o_tick
);

    localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    logic [PRE_W-1:0]    r_presc;
    logic                r_tick;
    logic [PWM_BITS-1:0] r_pwm;
    logic                r_cfg_ready;
    logic                w_accept;

    assign w_accept      = cfg.cfg_valid && r_cfg_ready;
    assign cfg.cfg_ready = r_cfg_ready;
    assign o_tick        = r_tick;

    // Tick prescaler, free-running PWM counter and write-ready flag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_presc     <= '0;
            r_tick      <= 1'b0;
            r_pwm       <= '0;
            r_cfg_ready <= 1'b0;
        end else begin
            r_presc     <= (r_presc == PRE_MAX) ? '0 : r_presc + PRE_W'(1);
            r_tick      <= (r_presc == PRE_MAX);
            r_pwm       <= r_pwm + PWM_BITS'(1);
            r_cfg_ready <= 1'b1;
        end
    end

    for (genvar n = 0; n < int'(CHANNELS); n++) begin : g_ch
        mode_e                   r_mode;
        logic [PERIOD_WIDTH-1:0] r_period;
        logic [PERIOD_WIDTH-1:0] r_phase;
        logic [PWM_BITS-1:0]     r_duty;
        logic                    r_dir_down;
        logic                    r_blink;
        logic                    r_led;
        logic                    w_wr;
        logic                    w_adv;
        logic                    w_step;
        logic [PERIOD_WIDTH-1:0] w_last;
        logic                    w_led;

        // Out-of-range channel indices match no channel, so they are dropped.
        assign w_wr   = w_accept && (cfg.cfg_channel == CH_W'(n));
        // A stored period of 0 runs like a period of 1.
        assign w_last = (r_period == '0) ? '0 : r_period - PERIOD_WIDTH'(1);
        assign w_adv  = r_tick && ((r_mode == MODE_BLINK) || (r_mode == MODE_BREATHE));
        assign w_step = w_adv && (r_phase == w_last);

        // LED level implied by the current channel state.
        always_comb begin
            w_led = 1'b0;
            unique case (r_mode)
                MODE_OFF:     w_led = 1'b0;
                MODE_ON:      w_led = 1'b1;
                MODE_BLINK:   w_led = r_blink;
                MODE_BREATHE: w_led = (r_pwm < r_duty);
            endcase
        end

        // Channel state; a write on a tick cycle wins and the tick is dropped.
        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                r_mode     <= MODE_OFF;
                r_period   <= '0;
                r_phase    <= '0;
                r_duty     <= '0;
                r_dir_down <= 1'b0;
                r_blink    <= 1'b0;
                r_led      <= 1'b0;
            end else begin
                r_led <= w_led;
                if (w_wr) begin
                    r_mode     <= mode_e'(cfg.cfg_mode);
                    r_period   <= cfg.cfg_period;
                    r_phase    <= '0;
                    r_duty     <= '0;
                    r_dir_down <= 1'b0;
                    r_blink    <= 1'b1;
                end else if (w_adv) begin
                    r_phase <= w_step ? '0 : r_phase + PERIOD_WIDTH'(1);
                    if (w_step) begin
                        if (r_mode == MODE_BLINK) begin
                            r_blink <= ~r_blink;
                        end else if (!r_dir_down) begin
                            // Top endpoint is held for one step before descending.
                            if (r_duty == DUTY_MAX) r_dir_down <= 1'b1;
                            else                    r_duty     <= r_duty + PWM_BITS'(1);
                        end else begin
                            if (r_duty == '0) r_dir_down <= 1'b0;
                            else              r_duty     <= r_duty - PWM_BITS'(1);
                        end
                    end
                end
            end
        end

        assign o_leds[n] = r_led;
    end

endmodule

// File: tb/tb_led_pattern_bank.sv
module tb_led_pattern_bank;

    localparam int unsigned CHANNELS = 6;
    localparam int END_CYC = 625;

    logic                clk;
    logic                rst;
    logic [CHANNELS-1:0] leds;
    logic                tick;

    led_pattern_bank_if #(.CH_W(3), .PERIOD_WIDTH(8)) cfg_if ();

    led_pattern_bank #(
        .CHANNELS    (CHANNELS),
        .TICK_DIV    (4),
        .PERIOD_WIDTH(8),
        .PWM_BITS    (3)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .cfg    (cfg_if),
        .o_leds (leds),
        .o_tick (tick)
    );

    typedef struct {
        int         e;
        int         kind;   // 0 leds (masked), 1 tick, 2 cfg_ready
        logic [5:0] mask;
        logic [5:0] val;
        string      name;
    } item_t;

    item_t sb_q[$];
    item_t it;
    int    edge_n  = 0;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    duty_tab [0:16] = '{1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic push(input int e, input int kind, input logic [5:0] mask,
                        input int val, input string name);
        item_t x;
        x.e = e; x.kind = kind; x.mask = mask; x.val = 6'(val); x.name = name;
        sb_q.push_back(x);
    endtask

    // Expected outputs after edge e, hand-derived from the stimulus schedule.
    task automatic gen_checks(input int e);
        int r, t, dt, pw;
        r = (e >= 562) ? 562 : 3;
        t = ((e >= r + 4) && ((e - r) % 4 == 0)) ? 1 : 0;
        push(e, 1, 6'h00, t, "tick");
        push(e, 2, 6'h00, (e <= 3 || e == 562) ? 0 : 1, "cfg_ready");
        if (e <= 205 || (e >= 212 && e <= 213) || (e >= 491 && e <= 510) ||
            (e >= 562 && e <= 621))
            push(e, 0, 6'h3f, 0, "leds_dark");
        if ((e >= 206 && e <= 211) || e >= 622)
            push(e, 0, 6'h3f, 1, "ch0_on");
        if (e >= 214 && e <= 344) begin
            if (e == 214)     t = 0;
            else if (e < 225) t = 1;
            else              t = (((e - 225) / 12) % 2 == 0) ? 0 : 1;
            push(e, 0, 6'h04, t << 2, "ch2_blink");
        end
        if (e >= 346 && e <= 488) begin
            dt = (e <= 352) ? 0 : duty_tab[(e - 353) / 8];
            pw = (e - 4) % 8;
            push(e, 0, 6'h20, (pw < dt) ? 6'h20 : 0, "ch5_breathe");
        end
        if (e >= 512 && e <= 532) begin
            t = (e == 512) ? 0 : (e <= 520) ? 1 : (e <= 528) ? 0 : 1;
            push(e, 0, 6'h02, t << 1, "ch1_blink_tick_collide");
        end
        if (e >= 521 && e <= 536) begin
            t = (e == 521) ? 0 : (((e - 521) / 4) % 2 == 0) ? 1 : 0;
            push(e, 0, 6'h08, t << 3, "ch3_blink_period0");
        end
        if (e >= 539 && e <= 561) begin
            t = (e == 539) ? 0 : (e == 540) ? 1 : (((e - 541) / 4) % 2 == 0) ? 0 : 1;
            push(e, 0, 6'h10, t << 4, "ch4_blink_p1");
        end
        if (e == 561)
            push(e, 0, 6'h08, 6'h08, "ch3_breathe_midramp");
    endtask

    // Monitor: pops expectations due at this edge and compares.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].e <= edge_n) begin
            logic [5:0] act;
            it = sb_q.pop_front();
            n_checks++;
            if (it.e < edge_n) begin
                $display("FAIL %s edge %0d: check missed (now edge %0d)", it.name, it.e, edge_n);
            end else begin
                case (it.kind)
                    0:       act = leds & it.mask;
                    1:       act = {5'b0, tick};
                    default: act = {5'b0, cfg_if.cfg_ready};
                endcase
                if (act === (it.val & ((it.kind == 0) ? it.mask : 6'h01))) n_pass++;
                else $display("FAIL %s edge %0d: got %b expected %b", it.name, it.e, act, it.val);
            end
        end
    end

    task automatic wr(input int ch, input int mode, input int period);
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_channel = 3'(ch);
        cfg_if.cfg_mode    = 2'(mode);
        cfg_if.cfg_period  = 8'(period);
    endtask

    initial begin
        int c;
        rst                = 1'b1;
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_channel = '0;
        cfg_if.cfg_mode    = '0;
        cfg_if.cfg_period  = '0;
        gen_checks(1);
        forever begin
            @(negedge clk);
            c = edge_n;
            if (c >= END_CYC) break;
            cfg_if.cfg_valid = 1'b0;
            case (c)
                3:   rst = 1'b0;
                204: wr(0, 1, 0);
                210: wr(0, 0, 0);
                213: wr(2, 2, 3);
                345: wr(5, 3, 2);
                488: wr(2, 0, 0);
                489: wr(5, 0, 0);
                490: wr(7, 2, 1);
                511: wr(1, 2, 2);
                520: wr(3, 2, 0);
                537: wr(3, 3, 1);
                538: wr(4, 2, 1);
                561: rst = 1'b1;
                562: rst = 1'b0;
                620: wr(0, 1, 0);
                default: ;
            endcase
            gen_checks(c + 1);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish by 20000 time units");
        $fatal(1);
    end

endmodule
